mem_port2_master: RTL

Initiator for the second (data) port of the multiport RAM unit. It accepts load/store requests from the execute stage and sequences them onto the RAM's single-issue port2 protocol. It returns one response per request and reports a fetch-stall so the core treats the instruction slot as a bubble while a data access owns the RAM. It sits between the CPU execute/writeback logic and the RAM unit.

---
 rtl/mem_port2_master_if.sv | 45 ++++
 rtl/mem_port2_master.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_port2_master_if.sv
// rtl/mem_port2_master_if.sv - request/response and RAM port2 bundle for mem_port2_master
//
// Groups the execute-stage request/response handshake, the fetch-stall flag and
// the RAM port2 signals.
//   master modport : the mem_port2_master view
//   slave modport  : the CPU/RAM environment view
// Access mode encoding on req_mode/memMode: 0 = byte, 1 = halfword, 2 = word.
`timescale 1ns/1ps

interface mem_port2_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_mode;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        fetch_stall;

    logic        ram_idle;
    logic        port2en;
    logic        port2WEn;
    logic [31:0] port2adr;
    logic [31:0] port2i;
    logic [1:0]  memMode;
    logic [31:0] port2o;
    logic        port2avail;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_mode,
        input  ram_idle, port2o, port2avail,
        output req_ready, resp_valid, resp_rdata, resp_fault, fetch_stall,
        output port2en, port2WEn, port2adr, port2i, memMode
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_mode,
        output ram_idle, port2o, port2avail,
        input  req_ready, resp_valid, resp_rdata, resp_fault, fetch_stall,
        input  port2en, port2WEn, port2adr, port2i, memMode
    );
endinterface

// File: rtl/mem_port2_master.sv
// rtl/mem_port2_master.sv - load/store sequencer for the RAM data port (port2)
//
// Accepts one load/store at a time from the execute stage, issues it to the
// RAM's single-issue port2, and returns exactly one response per request.
// fetch_stall is high whenever a data access owns the RAM.
//
// Ports:
//   clk   : clock
//   reset : asynchronous, active-low reset
//   bus   : mem_port2_master_if.master (request, response, fetch_stall, RAM port2)
// Parameters:
//   MEM_BYTES : addressable bytes; addresses at or above fault
//   TIMEOUT   : max cycles waiting for port2avail on a load before faulting
// Build option:
//   MEM_PORT2_ALIGN_CHECK_EN : when defined, misaligned halfword/word accesses fault
`timescale 1ns/1ps

module mem_port2_master #(
    parameter int MEM_BYTES = 131072,
    parameter int TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port2_master_if.master    bus
);
    localparam int         CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [1:0] MODE_HALF = 2'd1;
    localparam logic [1:0] MODE_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        WR_WAIT1,
        WR_WAIT2,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               load_port;

    logic               we_q;
    logic [31:0]        adr_q;
    logic [31:0]        wdat_q;
    logic [1:0]         mode_q;

    logic               accept;
    logic               range_fault;
    logic               align_fault;
    logic               req_fault;

    assign bus.req_ready = (state_q == IDLE) && bus.ram_idle;
    assign accept        = bus.req_valid && bus.req_ready;

    assign range_fault = bus.req_addr >= 32'(MEM_BYTES);

`ifdef MEM_PORT2_ALIGN_CHECK_EN
    assign align_fault = ((bus.req_mode == MODE_HALF) && bus.req_addr[0]) ||
                         ((bus.req_mode == MODE_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    // Unaligned addresses go to the RAM untouched; its lane logic uses addr[1:0].
    assign align_fault = 1'b0;
`endif

    assign req_fault = range_fault || align_fault;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        rdata_d   = rdata_q;
        load_port = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (req_fault) begin
                        // Faulting requests never touch port2.
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        fault_d   = 1'b0;
                        load_port = 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = we_q ? WR_WAIT1 : RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.port2avail) begin
                    rdata_d = bus.port2o;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            // Two dead cycles cover the RAM's read-then-rewrite of the target word.
            WR_WAIT1: state_d = WR_WAIT2;
            WR_WAIT2: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q   <= 1'b0;
            adr_q  <= '0;
            wdat_q <= '0;
            mode_q <= MODE_WORD;
        end else if (load_port) begin
            we_q   <= bus.req_we;
            adr_q  <= bus.req_addr;
            wdat_q <= bus.req_wdata;
            mode_q <= bus.req_mode;
        end
    end

    // Enables decode only from ISSUE, so each request pulses port2en exactly once.
    assign bus.port2en    = (state_q == ISSUE);
    assign bus.port2WEn   = (state_q == ISSUE) && we_q;
    assign bus.port2adr   = adr_q;
    assign bus.port2i     = wdat_q;
    assign bus.memMode    = mode_q;

    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_fault  = (state_q == RESP) && fault_q;
    assign bus.resp_rdata  = (state_q == RESP) ? rdata_q : 32'h0;
    assign bus.fetch_stall = (state_q != IDLE);

endmodule
